programmable_clock_divider: RTL and testbench
=============================================

# programmable_clock_divider

Multi-channel, runtime-programmable clock-enable/divided-clock generator that supersedes the fixed-ratio divider. Each channel produces a registered divided clock with a programmable period and high time in system-clock cycles, glitch-free reconfiguration at period boundaries, a runt-free stop, and a rising-edge tick. The block sits beside the system clock source and feeds peripherals (UART/SPI bit clocks, LED scanners, sample strobes) from one 100 MHz `clk`.

## Interface
- `CHANNELS`, 4: number of independent divider channels (1..16).
- `CNT_WIDTH`, 16: width of the period/high-time fields and the per-channel counter.
- `IDLE_STATE`, 0: output level while a channel is stopped; the active (high-time) level is `~IDLE_STATE`.
- `ROUND_MODE`, 1: selects the automatic 50 % high time when `cfg_high` = 0. 0 = floor(period/2); 1 = ceil(period/2).
- `DEFAULT_DIV`, 3: period loaded at reset.
- `DEFAULT_HIGH`, 0: high time loaded at reset; 0 = automatic.
- `clk` in 1: system clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `enable` in CHANNELS: per-channel run request, level-sensitive.
- `cfg_load` in CHANNELS: per-channel one-cycle strobe that captures the config fields into the shadow register.
- `cfg_div` in CHANNELS*CNT_WIDTH: packed periods; channel i uses bits [i*CNT_WIDTH +: CNT_WIDTH].
- `cfg_high` in CHANNELS*CNT_WIDTH: packed high times, with the same packing.
- `sync_start` in 1: one-cycle strobe that phase-aligns all running channels.
- `divided_clk_out` out CHANNELS: registered divided clocks.
- `rise_tick` out CHANNELS: one-cycle pulse, registered and coincident with the cycle in which `divided_clk_out[i]` becomes active.
- `cfg_pending` out CHANNELS: the shadow config has not yet been applied.
- `running` out CHANNELS: the channel is in RUN or STOPPING.

## Operation
- **Per-channel state.** Each channel keeps the following registers:
  - `cnt` (CNT_WIDTH bits).
  - Active `period` and `high`.
  - Shadow `period` and `high`.
  - `pending` flag.
  - A 3-state FSM: IDLE, RUN, STOPPING.
- **Effective values.** These are computed when a config is applied, never mid-period.
  - If period < 2, the period is 2.
  - If high = 0, the high time is floor or ceil of period/2, per `ROUND_MODE`.
  - The high time is then clamped to [1, period−1].
- **IDLE.**
  - `cnt` = 0 and the output is at `IDLE_STATE`.
  - When `enable[i]` = 1, go to RUN: apply any pending shadow config, `cnt` ← 0, and the output goes active.
- **RUN.**
  - The output is active while `cnt` < high and idle otherwise.
  - `cnt` increments each cycle and wraps to 0 after period−1.
  - On the wrap, a pending shadow config is applied and `pending` clears.
  - If `enable[i]` = 0, go to STOPPING.
- **STOPPING.**
  - The channel continues counting until `cnt` = period−1, so the current period completes and no runt pulse is produced.
  - It then goes to IDLE with the output at `IDLE_STATE`.
  - If `enable[i]` returns to 1 before the boundary, go back to RUN with no disturbance.
- **`cfg_load`.**
  - Captures `cfg_div` and `cfg_high` into the shadow register and sets `pending`.
  - A second load before the boundary overwrites the shadow; the last one wins.
  - If the channel is in IDLE, the config is applied on the next cycle.
- **`sync_start`.**
  - Every channel in RUN or STOPPING applies any pending config and sets `cnt` ← 0 on the next cycle, so all outputs go active together and `rise_tick` asserts.
  - Channels in IDLE ignore it.
- **Simultaneous events.**
  - `cfg_load` in the wrap cycle: the new values are captured into the shadow but are not applied until the following boundary.
  - `sync_start` together with `cfg_load`: sync applies the old shadow; the new load stays pending.
  - `enable` falling in the same cycle as `sync_start`: sync takes effect, then the channel goes to STOPPING.

## Timing
- **Reset values.**
  - `divided_clk_out` = {CHANNELS{IDLE_STATE}}.
  - `rise_tick` = 0, `cfg_pending` = 0, `running` = 0.
  - `cnt` = 0, all FSMs in IDLE.
  - Active and shadow config = `DEFAULT_DIV` / `DEFAULT_HIGH`.
- **Reset mid-operation.**
  - All of the above take effect at the edge where `rst` = 1, regardless of state.
  - Runt pulses are acceptable only on reset.
- **Enable latency.** `enable` sampled high at edge k → output active and `rise_tick` = 1 after edge k+1.
- **Output waveform.** Active for exactly high cycles, idle for period−high cycles, with no combinational path from inputs to outputs.
- **Config latency.**
  - `cfg_pending` rises one cycle after the `cfg_load` edge.
  - It falls in the same cycle the new period begins.
- **`running`.** Mirrors the FSM state, registered.

## Test plan
- **Basic enable.**
  - Stimulus: 100 MHz clock, `DEFAULT_DIV`=3, `ROUND_MODE`=1, `IDLE_STATE`=0, `enable[0]` rises at 10 ns.
  - Required response: output pattern 1,1,0 repeating (30 ns period), the first high one cycle after enable, and `rise_tick` every 3rd cycle.
- **Glitch-free reconfiguration.**
  - Stimulus: while running with div=3, `cfg_load` div=10, high=3 mid-period.
  - Required response: the current 3-cycle period completes unchanged, then 3 high / 7 low; `cfg_pending` is high exactly until that boundary.
- **Runt-free stop.**
  - Stimulus: with div=10, high=3, drop `enable` at `cnt`=1.
  - Required response: the output finishes 3 high / 7 low, then holds 0 and `running` falls. Re-asserting `enable` at `cnt`=5 keeps the waveform continuous.
- **Clamping.**
  - Stimulus: `cfg_div`=0 with high=0; then div=4 with high=9.
  - Required response: period 2 with 1 high / 1 low; then period 4 with 3 high / 1 low.
- **Sync.**
  - Stimulus: channels 0–3 run div=3, 4, 5, 7 with staggered enables; pulse `sync_start`.
  - Required response: all four outputs are active on the same cycle and all `rise_tick` bits pulse together.
- **Reset mid-operation.**
  - Stimulus: assert `rst` for 1 cycle while channels are in RUN and STOPPING with loads pending.
  - Required response: all outputs idle, ticks, pending and running all 0, and the config reverts to `DEFAULT_DIV`.

Source files
------------

// File: rtl/programmable_clock_divider_if.sv
// Control and status bundle for the multi-channel programmable clock divider.
// The master side (controller or bench) drives run requests, configuration
// fields and the global sync strobe. The slave side (the divider) returns the
// divided clocks, rise ticks and per-channel status flags.
interface programmable_clock_divider_if #(
  parameter int CHANNELS  = 4,
  parameter int CNT_WIDTH = 16
);

  // Per-channel run request, level-sensitive.
  logic [CHANNELS-1:0]           enable;
  // Per-channel one-cycle strobe that captures the fields below into the shadow config.
  logic [CHANNELS-1:0]           cfg_load;
  // Packed periods; channel i uses [i*CNT_WIDTH +: CNT_WIDTH].
  logic [CHANNELS*CNT_WIDTH-1:0] cfg_div;
  // Packed high times, same packing as cfg_div; 0 selects the automatic 50 % duty.
  logic [CHANNELS*CNT_WIDTH-1:0] cfg_high;
  // One-cycle strobe that restarts every running channel at phase zero.
  logic                          sync_start;

  // Registered divided clocks.
  logic [CHANNELS-1:0]           divided_clk_out;
  // One-cycle pulse in the first active cycle of every period.
  logic [CHANNELS-1:0]           rise_tick;
  // Shadow config captured but not yet in use.
  logic [CHANNELS-1:0]           cfg_pending;
  // Channel is producing a waveform (running or finishing its last period).
  logic [CHANNELS-1:0]           running;

  modport master (
    output enable,
    output cfg_load,
    output cfg_div,
    output cfg_high,
    output sync_start,
    input  divided_clk_out,
    input  rise_tick,
    input  cfg_pending,
    input  running
  );

  modport slave (
    input  enable,
    input  cfg_load,
    input  cfg_div,
    input  cfg_high,
    input  sync_start,
    output divided_clk_out,
    output rise_tick,
    output cfg_pending,
    output running
  );

endinterface

// File: rtl/programmable_clock_divider.sv
// Multi-channel programmable divided-clock generator.
// Each channel counts system-clock cycles through a programmable period and
// drives its output active for the first 'high' cycles of every period.
// New configurations are held in a shadow register and only take effect at a
// period boundary (or immediately while the channel is idle), so a running
// waveform never shows a shortened or stretched pulse. Dropping the run
// request lets the current period finish before the channel goes idle.
// All outputs are registered from the internal state, so every status and
// waveform output lags the counter by exactly one cycle and stays aligned
// with the others.
module programmable_clock_divider #(
  parameter int   CHANNELS     = 4,
  parameter int   CNT_WIDTH    = 16,
  parameter logic IDLE_STATE   = 1'b0,
  parameter int   ROUND_MODE   = 1,
  parameter int   DEFAULT_DIV  = 3,
  parameter int   DEFAULT_HIGH = 0
) (
  input logic                         clk,
  input logic                         rst,
  programmable_clock_divider_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] ONE        = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] TWO        = CNT_WIDTH'(2);
  localparam logic [CNT_WIDTH-1:0] DEF_DIV    = CNT_WIDTH'(DEFAULT_DIV);
  localparam logic [CNT_WIDTH-1:0] DEF_HIGH   = CNT_WIDTH'(DEFAULT_HIGH);
  localparam logic                 ACTIVE_LVL = ~IDLE_STATE;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_e;

  // Effective period: anything below 2 cannot produce both an active and an
  // idle phase, so it is raised to 2.
  function automatic logic [CNT_WIDTH-1:0] eff_period(input logic [CNT_WIDTH-1:0] div);
    eff_period = (div < TWO) ? TWO : div;
  endfunction

  // Effective high time: 0 selects half the period (floor or ceil), then the
  // result is clamped so at least one active and one idle cycle remain.
  // Half of a period >= 2 is already >= 1, so only the upper clamp is needed.
  function automatic logic [CNT_WIDTH-1:0] eff_high(input logic [CNT_WIDTH-1:0] div,
                                                    input logic [CNT_WIDTH-1:0] high);
    logic [CNT_WIDTH-1:0] p;
    logic [CNT_WIDTH-1:0] h;
    p = eff_period(div);
    if (high == '0) begin
      // ceil(p/2) written as floor(p/2) + lsb so it cannot overflow at p = max
      h = (p >> 1) + ((ROUND_MODE != 0) ? {{(CNT_WIDTH-1){1'b0}}, p[0]} : '0);
    end else begin
      h = high;
    end
    if (h > p - ONE) begin
      h = p - ONE;
    end
    eff_high = h;
  endfunction

  logic [CHANNELS-1:0] clk_out_w;
  logic [CHANNELS-1:0] tick_w;
  logic [CHANNELS-1:0] pend_w;
  logic [CHANNELS-1:0] run_w;

  assign bus.divided_clk_out = clk_out_w;
  assign bus.rise_tick       = tick_w;
  assign bus.cfg_pending     = pend_w;
  assign bus.running         = run_w;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] per_q, per_d;         // active effective period
    logic [CNT_WIDTH-1:0] high_q, high_d;       // active effective high time
    logic [CNT_WIDTH-1:0] sh_div_q, sh_div_d;   // shadow raw period
    logic [CNT_WIDTH-1:0] sh_high_q, sh_high_d; // shadow raw high time
    logic                 pend_q, pend_d;

    logic                 out_q;
    logic                 tick_q;
    logic                 pend_out_q;
    logic                 run_out_q;

    logic                 en;
    logic                 load;
    logic                 at_end;
    logic                 apply;
    logic [CNT_WIDTH-1:0] div_in;
    logic [CNT_WIDTH-1:0] high_in;

    assign en      = bus.enable[gi];
    assign load    = bus.cfg_load[gi];
    assign div_in  = bus.cfg_div[gi*CNT_WIDTH +: CNT_WIDTH];
    assign high_in = bus.cfg_high[gi*CNT_WIDTH +: CNT_WIDTH];

    // Last cycle of the current period; '>=' keeps the counter from running
    // away should it ever sit beyond the active period.
    assign at_end = (cnt_q >= per_q - ONE);

    // FSM next state and counter: decides where a period boundary happens and
    // whether the shadow config is applied on it.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      apply   = 1'b0;
      case (state_q)
        ST_IDLE: begin
          // Idle channels absorb a pending config right away.
          cnt_d = '0;
          apply = pend_q;
          if (en) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN, ST_STOPPING: begin
          if (bus.sync_start) begin
            // Forced phase restart; a dropped enable still finishes this new period.
            cnt_d   = '0;
            apply   = pend_q;
            state_d = en ? ST_RUN : ST_STOPPING;
          end else if (en) begin
            // Running, or resumed from stopping without touching the phase.
            state_d = ST_RUN;
            if (at_end) begin
              cnt_d = '0;
              apply = pend_q;
            end else begin
              cnt_d = cnt_q + ONE;
            end
          end else if (at_end) begin
            // Period finished with no run request: park at the idle level.
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            // Run request gone mid-period: let the period complete.
            state_d = ST_STOPPING;
            cnt_d   = cnt_q + ONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Shadow capture and active-config update. A load in the same cycle as an
    // apply is kept pending: the apply uses the shadow as it was before the load.
    always_comb begin
      sh_div_d  = sh_div_q;
      sh_high_d = sh_high_q;
      per_d     = per_q;
      high_d    = high_q;
      pend_d    = pend_q;
      if (apply) begin
        per_d  = eff_period(sh_div_q);
        high_d = eff_high(sh_div_q, sh_high_q);
        pend_d = 1'b0;
      end
      if (load) begin
        sh_div_d  = div_in;
        sh_high_d = high_in;
        pend_d    = 1'b1;
      end
    end

    // State, counter and configuration registers.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q   <= ST_IDLE;
        cnt_q     <= '0;
        per_q     <= eff_period(DEF_DIV);
        high_q    <= eff_high(DEF_DIV, DEF_HIGH);
        sh_div_q  <= DEF_DIV;
        sh_high_q <= DEF_HIGH;
        pend_q    <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        per_q     <= per_d;
        high_q    <= high_d;
        sh_div_q  <= sh_div_d;
        sh_high_q <= sh_high_d;
        pend_q    <= pend_d;
      end
    end

    // Output registers: waveform, tick and status all derive from the same
    // state snapshot, so they change together one cycle after the counter.
    always_ff @(posedge clk) begin
      if (rst) begin
        out_q      <= IDLE_STATE;
        tick_q     <= 1'b0;
        pend_out_q <= 1'b0;
        run_out_q  <= 1'b0;
      end else begin
        out_q      <= ((state_q != ST_IDLE) && (cnt_q < high_q)) ? ACTIVE_LVL : IDLE_STATE;
        tick_q     <= (state_q != ST_IDLE) && (cnt_q == '0);
        pend_out_q <= pend_q;
        run_out_q  <= (state_q != ST_IDLE);
      end
    end

    assign clk_out_w[gi] = out_q;
    assign tick_w[gi]    = tick_q;
    assign pend_w[gi]    = pend_out_q;
    assign run_w[gi]     = run_out_q;

  end

endmodule

// File: tb/tb_programmable_clock_divider.sv
// Bench for programmable_clock_divider: directed stimulus, literal waveform
// expectations, and a period-level reference model that predicts every
// output cycle by cycle.
module tb_programmable_clock_divider;

  localparam int CH = 4;
  localparam int W  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_mis = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  programmable_clock_divider_if #(.CHANNELS(CH), .CNT_WIDTH(W)) bus ();

  programmable_clock_divider #(
    .CHANNELS(CH), .CNT_WIDTH(W), .IDLE_STATE(1'b0), .ROUND_MODE(1),
    .DEFAULT_DIV(3), .DEFAULT_HIGH(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s cycle=%0d actual=%b required=%b", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Each running channel holds the not-yet-shown part of its current period
  // as a queue of {tick,level} entries; decisions are taken only when the
  // queue runs dry (period boundary), on sync, or while idle.
  int   q[CH][$];
  bit   m_act[CH];
  bit   m_pend[CH];
  int   sh_div[CH], sh_high[CH], act_div[CH], act_high[CH];
  logic [CH-1:0] exp_out, exp_tick, exp_pend, exp_run;
  logic [CH-1:0] nxt_out, nxt_tick, nxt_pend, nxt_run;
  bit   m_valid = 1'b0;

  function automatic int eff_p(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  function automatic int eff_h(input int d, input int h);
    int p, r;
    p = eff_p(d);
    r = (h == 0) ? (p + 1) / 2 : h;
    if (r > p - 1) r = p - 1;
    if (r < 1) r = 1;
    return r;
  endfunction

  function automatic void fill(input int c);
    int p, h;
    p = eff_p(act_div[c]);
    h = eff_h(act_div[c], act_high[c]);
    q[c].delete();
    for (int i = 0; i < p; i++) q[c].push_back(((i == 0) ? 2 : 0) + ((i < h) ? 1 : 0));
  endfunction

  function automatic void apply_cfg(input int c);
    if (m_pend[c]) begin
      act_div[c]  = sh_div[c];
      act_high[c] = sh_high[c];
      m_pend[c]   = 1'b0;
    end
  endfunction

  initial begin
    bit en, ld, sy;
    int v;
    forever begin
      @(posedge clk);
      if (rst) begin
        for (int c = 0; c < CH; c++) begin
          q[c].delete();
          m_act[c] = 1'b0; m_pend[c] = 1'b0;
          sh_div[c] = 3; sh_high[c] = 0; act_div[c] = 3; act_high[c] = 0;
        end
        exp_out = '0; exp_tick = '0; exp_pend = '0; exp_run = '0;
        nxt_out = '0; nxt_tick = '0; nxt_pend = '0; nxt_run = '0;
        m_valid = 1'b1;
      end else begin
        exp_out = nxt_out; exp_tick = nxt_tick; exp_pend = nxt_pend; exp_run = nxt_run;
        sy = bus.sync_start;
        for (int c = 0; c < CH; c++) begin
          en = bus.enable[c];
          ld = bus.cfg_load[c];
          if (!m_act[c]) begin
            apply_cfg(c);
            if (en) begin m_act[c] = 1'b1; fill(c); end
          end else if (sy) begin
            apply_cfg(c); fill(c);
          end else if (q[c].size() == 0) begin
            if (en) begin apply_cfg(c); fill(c); end
            else m_act[c] = 1'b0;
          end
          if (ld) begin
            sh_div[c]  = int'(bus.cfg_div[c*W +: W]);
            sh_high[c] = int'(bus.cfg_high[c*W +: W]);
            m_pend[c]  = 1'b1;
          end
          if (m_act[c]) begin
            v = q[c].pop_front();
            nxt_out[c] = v[0]; nxt_tick[c] = v[1];
          end else begin
            nxt_out[c] = 1'b0; nxt_tick[c] = 1'b0;
          end
          nxt_pend[c] = m_pend[c];
          nxt_run[c]  = m_act[c];
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        check("model_divided_clk_out", 32'(bus.divided_clk_out), 32'(exp_out));
        check("model_rise_tick",       32'(bus.rise_tick),       32'(exp_tick));
        check("model_cfg_pending",     32'(bus.cfg_pending),     32'(exp_pend));
        check("model_running",         32'(bus.running),         32'(exp_run));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (actual timeout, required $finish)");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus helpers ----------------
  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tick(input int c, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.rise_tick[c]) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_cmp++; n_mis++;
      $display("FAIL wait_tick ch%0d cycle=%0d actual=no_pulse required=pulse_within_40", c, cyc);
    end
  endtask

  // Waits for the next tick on channel c and shifts in n output samples,
  // the tick cycle first (MSB).
  task automatic capture(input int c, input int n, output logic [31:0] bits);
    bit ok;
    bits = '0;
    wait_tick(c, ok);
    bits = {bits[30:0], bus.divided_clk_out[c]};
    for (int i = 1; i < n; i++) begin
      @(negedge clk);
      bits = {bits[30:0], bus.divided_clk_out[c]};
    end
  endtask

  task automatic load(input int c, input int div, input int high);
    bus.cfg_load[c] = 1'b1;
    bus.cfg_div[c*W +: W]  = W'(div);
    bus.cfg_high[c*W +: W] = W'(high);
    @(negedge clk);
    bus.cfg_load = '0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] bits, tbits, rbits;
    bit ok;
    bus.enable = '0; bus.cfg_load = '0; bus.cfg_div = '0; bus.cfg_high = '0; bus.sync_start = 1'b0;
    rst = 1'b1;
    nclk(3);
    check("reset_divided_clk_out", 32'(bus.divided_clk_out), 32'h0);
    check("reset_rise_tick",       32'(bus.rise_tick),       32'h0);
    check("reset_cfg_pending",     32'(bus.cfg_pending),     32'h0);
    check("reset_running",         32'(bus.running),         32'h0);
    rst = 1'b0;
    nclk(2);

    // Basic enable with the reset default div=3, auto high (ceil) = 2.
    bus.enable[0] = 1'b1;
    bits = '0; tbits = '0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      bits  = {bits[30:0], bus.divided_clk_out[0]};
      tbits = {tbits[30:0], bus.rise_tick[0]};
    end
    check("basic_wave", bits,  32'b0110110);
    check("basic_tick", tbits, 32'b0100100);

    // Reconfigure mid-period: old period finishes, then 3 high / 7 low.
    wait_tick(0, ok);
    load(0, 10, 3);
    capture(0, 10, bits);
    check("reconfig_wave", bits, 32'b1110000000);

    // Runt-free stop: drop enable at cnt=1.
    wait_tick(0, ok);
    bus.enable[0] = 1'b0;
    bits = '0; rbits = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bits  = {bits[30:0], bus.divided_clk_out[0]};
      rbits = {rbits[30:0], bus.running[0]};
    end
    check("stop_wave",    bits,  32'b110000000000);
    check("stop_running", rbits, 32'b111111111000);

    // Stop request withdrawn at cnt=5: waveform continues undisturbed.
    bus.enable[0] = 1'b1;
    wait_tick(0, ok);
    bits  = {31'b0, bus.divided_clk_out[0]};
    rbits = {31'b0, bus.running[0]};
    bus.enable[0] = 1'b0;
    for (int i = 1; i < 20; i++) begin
      @(negedge clk);
      bits  = {bits[30:0], bus.divided_clk_out[0]};
      rbits = {rbits[30:0], bus.running[0]};
      if (i == 4) bus.enable[0] = 1'b1;
    end
    check("resume_wave",    bits,  32'b11100000001110000000);
    check("resume_running", rbits, 32'hFFFFF);

    // Clamping on channel 1: div=0/high=0 -> 2 with 1 high.
    load(1, 0, 0);
    nclk(2);
    bus.enable[1] = 1'b1;
    capture(1, 4, bits);
    check("clamp_div0", bits, 32'b1010);
    // Load in the wrap cycle: one more old period, then 4 with 3 high.
    wait_tick(1, ok);
    load(1, 4, 9);
    capture(1, 8, bits);
    check("clamp_high9_wrapload", bits, 32'b10111011);

    // Sync: channels at 3, 4, 5, 7 with staggered enables.
    bus.cfg_load = 4'b1111;
    bus.cfg_div  = {16'd7, 16'd5, 16'd4, 16'd3};
    bus.cfg_high = '0;
    @(negedge clk);
    bus.cfg_load = '0;
    bus.enable[2] = 1'b1;
    @(negedge clk);
    bus.enable[3] = 1'b1;
    nclk(15);
    // Sync together with a load on ch3 and enable falling on ch2.
    bus.sync_start = 1'b1;
    bus.enable[2]  = 1'b0;
    bus.cfg_load   = 4'b1000;
    bus.cfg_div[3*W +: W] = 16'd9;
    @(negedge clk);
    bus.sync_start = 1'b0;
    bus.cfg_load   = '0;
    @(negedge clk);
    check("sync_outputs",    32'(bus.divided_clk_out), 32'hF);
    check("sync_ticks",      32'(bus.rise_tick),       32'hF);
    check("sync_ch3_pending", 32'(bus.cfg_pending[3]), 32'h1);

    // Reset mid-operation: ch2 stopping, ch3 and ch0 with pending loads.
    @(negedge clk);
    bus.cfg_load[0] = 1'b1;
    bus.cfg_div[0*W +: W] = 16'd8;
    @(negedge clk);
    bus.cfg_load = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midreset_divided_clk_out", 32'(bus.divided_clk_out), 32'h0);
    check("midreset_rise_tick",       32'(bus.rise_tick),       32'h0);
    check("midreset_cfg_pending",     32'(bus.cfg_pending),     32'h0);
    check("midreset_running",         32'(bus.running),         32'h0);
    capture(0, 6, bits);
    check("midreset_default_wave", bits, 32'b110110);

    nclk(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
